// File: rtl/psig_pkg.sv
// Shared widths, fixed-point constants, mode encoding and stage payload types
// for the PSigmoid forward path and its gradient unit.
package psig_pkg;

    localparam int unsigned WI_Y  = 8;
    localparam int unsigned WF_Y  = 6;
    localparam int unsigned WI_G  = 6;
    localparam int unsigned WF_G  = 14;
    localparam int unsigned WF_D  = 2 * WF_Y;
    localparam int unsigned CNT_W = 16;

    localparam int unsigned Y_W = WI_Y + WF_Y;
    localparam int unsigned G_W = WI_G + WF_G;
    localparam int unsigned D_W = WF_D + 1;
    localparam int unsigned P_W = 2 * Y_W;
    localparam int unsigned M_W = G_W + D_W + 1;

    localparam int unsigned FP_ONE_Y = 1 << WF_Y;
    localparam int unsigned FP_ONE_D = 1 << WF_D;

    typedef enum logic {
        MODE_TANH   = 1'b0,
        MODE_LOGSIG = 1'b1
    } mode_e;

    // Unsigned Q1.12 derivative, always within [0, 1.0]
    typedef logic [D_W-1:0] deriv_t;

    // t is one bit wider than y so fpOne - y cannot wrap for very negative y
    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [Y_W:0]   t;
        logic [G_W-1:0] dy;
        mode_e          mode;
        logic           relu;
    } s1_t;

    typedef struct packed {
        deriv_t         d;
        logic [G_W-1:0] dy;
    } s2_t;

endpackage

// File: rtl/fxRoundSat.sv
// Round half-up, arithmetic shift right by SHIFT, then saturate to a signed
// OUT_W-bit result.
module fxRoundSat #(
    parameter int unsigned IN_W  = 34,
    parameter int unsigned SHIFT = 12,
    parameter int unsigned OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shr;

    // Extra headroom bit keeps the rounding add from overflowing
    always_comb begin
        sum = EXT_W'(din) + HALF;
        shr = sum >>> SHIFT;
        if (shr > SAT_MAX) begin
            dout = OUT_W'(SAT_MAX);
        end else if (shr < SAT_MIN) begin
            dout = OUT_W'(SAT_MIN);
        end else begin
            dout = OUT_W'(shr);
        end
    end

endmodule

// File: rtl/psig_grad.sv
// Three-stage activation-gradient pipeline: dx = dy * f'(y) for logsig, tanh
// or ReLU, with valid/ready backpressure and an output handshake counter.
module psig_grad
    import psig_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   y,
    input  logic [G_W-1:0]   dy,
    input  logic             modeSEL,
    input  logic             ReLU_EN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [G_W-1:0]   dx,
    output logic [CNT_W-1:0] txCount
);

    localparam logic signed [P_W:0] ONE_D_P = (P_W+1)'(FP_ONE_D);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic signed [Y_W:0]   y_ext;
    logic signed [P_W-1:0] p_c;
    logic signed [P_W:0]   raw_c;
    logic signed [M_W-1:0] m_c;
    logic [G_W-1:0]        dx_d;

    // A stage loads when empty or when its contents advance this cycle
    always_comb begin
        ld3 = !v3 || out_ready;
        ld2 = !v2 || ld3;
        ld1 = !v1 || ld2;
    end

    assign in_ready  = ld1;
    assign out_valid = v3;

    // S1: capture inputs and form the second factor of the derivative product
    always_comb begin
        y_ext     = (Y_W+1)'($signed(y));
        s1_d.y    = y;
        s1_d.dy   = dy;
        s1_d.mode = mode_e'(modeSEL);
        s1_d.relu = ReLU_EN;
        s1_d.t    = (mode_e'(modeSEL) == MODE_LOGSIG) ? ((Y_W+1)'(FP_ONE_Y) - y_ext) : y_ext;
    end

    // S2: derivative in Q1.12, clamped to [0, 1.0]
    always_comb begin
        p_c     = P_W'($signed(s1_q.y)) * P_W'($signed(s1_q.t));
        raw_c   = (s1_q.mode == MODE_LOGSIG) ? (P_W+1)'(p_c) : (ONE_D_P - (P_W+1)'(p_c));
        s2_d.dy = s1_q.dy;
        s2_d.d  = '0;
        if (s1_q.relu) begin
            s2_d.d = (!s1_q.y[Y_W-1] && (s1_q.y != '0)) ? D_W'(FP_ONE_D) : '0;
        end else if (raw_c[P_W]) begin
            s2_d.d = '0;
        end else if (raw_c > ONE_D_P) begin
            s2_d.d = D_W'(FP_ONE_D);
        end else begin
            s2_d.d = D_W'(raw_c);
        end
    end

    // S3: scale the gradient, then round back to Q6.14
    always_comb begin
        m_c = M_W'($signed(s2_q.dy)) * $signed(M_W'(s2_q.d));
    end

    fxRoundSat #(
        .IN_W  (M_W),
        .SHIFT (WF_D),
        .OUT_W (G_W)
    ) u_round_sat (
        .din  (m_c),
        .dout (dx_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            dx      <= '0;
            txCount <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) s2_q <= s2_d;
            end
            if (ld3) begin
                v3 <= v2;
                if (v2) dx <= dx_d;
            end
            if (v3 && out_ready) txCount <= txCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_psig_grad.sv
// Bench for psig_grad: directed vector table, randomized backpressure run
// against a reference model, and reset with transactions in flight.
module tb_psig_grad;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] y;
    logic [19:0] dy;
    logic        modeSEL;
    logic        ReLU_EN;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] dx;
    logic [15:0] txCount;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string name;
        int    yv;
        int    dyv;
        bit    mode;
        bit    relu;
        int    exp;
    } vec_t;

    vec_t vecs[16];

    psig_grad dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .dy        (dy),
        .modeSEL   (modeSEL),
        .ReLU_EN   (ReLU_EN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dx        (dx),
        .txCount   (txCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dx(input string name, input int e);
        logic [19:0] ev;
        ev = 20'(e);
        check(name, {12'd0, dx}, {12'd0, ev});
    endtask

    function automatic int ref_dx(input int yv, input int dyv, input bit lg, input bit rl);
        longint p, d, m;
        if (rl) begin
            d = (yv > 0) ? 64'sd4096 : 64'sd0;
        end else begin
            p = lg ? longint'(yv) * longint'(64 - yv) : longint'(yv) * longint'(yv);
            d = lg ? p : 64'sd4096 - p;
            if (d < 0) d = 0;
            if (d > 4096) d = 4096;
        end
        m = longint'(dyv) * d + 64'sd2048;
        m = m >>> 12;
        if (m > 524287) m = 524287;
        if (m < -524288) m = -524288;
        return int'(m);
    endfunction

    // Single transaction into an empty pipe with out_ready held high; called at posedge+1
    task automatic send_one(input vec_t v);
        y        = 14'(v.yv);
        dy       = 20'(v.dyv);
        modeSEL  = v.mode;
        ReLU_EN  = v.relu;
        in_valid = 1'b1;
        #1;
        check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check({v.name, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge CLK); #1;
        check({v.name, "_lat2"}, 32'(out_valid), 32'd0);
        @(posedge CLK); #1;
        check({v.name, "_lat3"}, 32'(out_valid), 32'd1);
        check_dx({v.name, "_dx"}, v.exp);
        @(posedge CLK); #1;
    endtask

    initial begin
        int ry[10];
        int rdy[10];
        bit rm[10];
        bit rr[10];
        int bq[$];
        int sent, got, occ, cyc, e;
        logic prev_stall;
        logic [19:0] prev_dx;
        logic [15:0] cnt0;

        vecs[0]  = '{"logsig_half",  32,   16384,  1'b1, 1'b0, 4096};
        vecs[1]  = '{"tanh_half",    32,   16384,  1'b0, 1'b0, 12288};
        vecs[2]  = '{"tanh_one",     64,   16384,  1'b0, 1'b0, 0};
        vecs[3]  = '{"tanh_neg",     -32,  -16384, 1'b0, 1'b0, -12288};
        vecs[4]  = '{"relu_pos",     192,  -5000,  1'b0, 1'b1, -5000};
        vecs[5]  = '{"relu_zero",    0,    -5000,  1'b1, 1'b1, 0};
        vecs[6]  = '{"relu_neg_m1",  -64,  7777,   1'b1, 1'b1, 0};
        vecs[7]  = '{"relu_neg_m0",  -64,  7777,   1'b0, 1'b1, 0};
        vecs[8]  = '{"logsig_neg",   -64,  16384,  1'b1, 1'b0, 0};
        vecs[9]  = '{"tanh_two",     128,  16384,  1'b0, 1'b0, 0};
        vecs[10] = '{"logsig_maxdy", 32,   524287, 1'b1, 1'b0, 131072};
        vecs[11] = '{"round_up",     16,   3,      1'b1, 1'b0, 1};
        vecs[12] = '{"round_neg",    16,   -3,     1'b1, 1'b0, -1};
        vecs[13] = '{"round_tie",    32,   -2,     1'b1, 1'b0, 0};
        vecs[14] = '{"relu_mindy",   1,    -524288, 1'b0, 1'b1, -524288};
        vecs[15] = '{"tanh_zero",    0,    100,    1'b0, 1'b0, 100};

        RST       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        y         = '0;
        dy        = '0;
        modeSEL   = 1'b0;
        ReLU_EN   = 1'b0;

        #1 RST = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_dx", {12'd0, dx}, 32'd0);
        check("reset_txcount", 32'(txCount), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) send_one(vecs[i]);
        check("table_txcount", 32'(txCount), 32'd16);

        // Backpressure: back-to-back inputs, random out_ready
        for (int i = 0; i < 10; i++) begin
            ry[i]  = int'($urandom_range(0, 255)) - 128;
            rdy[i] = int'($urandom_range(0, 1048575)) - 524288;
            rm[i]  = 1'($urandom_range(0, 1));
            rr[i]  = ($urandom_range(0, 3) == 0);
        end
        sent = 0; got = 0; occ = 0; cyc = 0;
        prev_stall = 1'b0;
        prev_dx = '0;
        cnt0 = txCount;
        while (got < 10 && cyc < 300) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 10) begin
                in_valid = 1'b1;
                y        = 14'(ry[sent]);
                dy       = 20'(rdy[sent]);
                modeSEL  = rm[sent];
                ReLU_EN  = rr[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(in_ready), 32'(!(occ == 3 && !out_ready)));
            if (prev_stall) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_dx", {12'd0, dx}, {12'd0, prev_dx});
            end
            if (out_valid && out_ready) begin
                if (bq.size() == 0) begin
                    check("bp_spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = bq.pop_front();
                    check_dx("bp_dx", e);
                end
                got++;
                occ--;
            end
            if (in_valid && in_ready) begin
                bq.push_back(ref_dx(ry[sent], rdy[sent], rm[sent], rr[sent]));
                sent++;
                occ++;
            end
            prev_stall = out_valid && !out_ready;
            prev_dx = dx;
            @(posedge CLK); #1;
            cyc++;
        end
        check("bp_completed", 32'(got), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_txcount", 32'(txCount), 32'(16'(cnt0 + 16'd10)));
        check("bp_txcount_abs", 32'(txCount), 32'd26);

        // Reset with two transactions in flight
        y = 14'd32; dy = 20'd16384; modeSEL = 1'b1; ReLU_EN = 1'b0; in_valid = 1'b1;
        @(posedge CLK); #1;
        y = 14'd16; dy = 20'd3;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check_dx("rst_pre_dx", 4096);
        #1 RST = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dx", {12'd0, dx}, 32'd0);
        check("rst_txcount", 32'(txCount), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("rst_txcount_after", 32'(txCount), 32'd0);
        send_one(vecs[1]);
        check("rst_txcount_next", 32'(txCount), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/psig_grad.md
# psig_grad

Pipelined activation-gradient unit for GRU backpropagation. It runs the PSigmoid activation path in reverse: it takes a stored activation output `y` (Q8.6, the PSigmoid output format) and an upstream gradient `dy` (Q6.14, the PSigmoid input format). It returns `dx = dy · f'(y)` for logsig, tanh or ReLU. Three registered stages with valid/ready backpressure sustain one result per cycle.

## Interface
- `WI_Y`, 8, activation integer bits (sign included)
- `WF_Y`, 6, activation fraction bits
- `WI_G`, 6, gradient integer bits (sign included)
- `WF_G`, 14, gradient fraction bits
- `WF_D`, 12, derivative fraction bits (= 2·WF_Y)
- `CNT_W`, 16, transaction counter width

- `CLK`  in  1  clock; all state changes on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input transaction present
- `in_ready`  out  1  unit accepts input this cycle
- `y`  in  WI_Y+WF_Y  signed activation value
- `dy`  in  WI_G+WF_G  signed upstream gradient
- `modeSEL`  in  1  1 = logsig, 0 = tanh (same encoding as PSigmoid)
- `ReLU_EN`  in  1  1 = ReLU derivative; overrides `modeSEL`
- `out_valid`  out  1  `dx` valid
- `out_ready`  in  1  downstream accepts `dx`
- `dx`  out  WI_G+WF_G  signed result gradient
- `txCount`  out  CNT_W  count of completed output handshakes; wraps

## Operation
- A transfer occurs on a rising edge when valid && ready on that side.
- `y`, `dy`, `modeSEL` and `ReLU_EN` are sampled together on input transfer. The mode fields travel with the data, so mixed modes may be interleaved.
- Stage 1 (S1) registers:
  - `y`, `dy`, mode bits
  - `t` = fpOne − `y` when logsig, `y` when tanh (Q8.6)
  - fpOne = 1 << WF_Y
- Stage 2 (S2), derivative `d`, unsigned Q1.12, 13 bits:
  - Full product `p = y·t` (2·(WI_Y+WF_Y) bits, WF_D fraction).
  - logsig: `d = p`.
  - tanh: `d = (1 << WF_D) − p`.
  - Clamp `d` to [0, 1 << WF_D]. This covers out-of-range `y`; for example, logsig with y<0 gives p<0, so d = 0.
  - ReLU: `d = (y > 0) ? 1 << WF_D : 0`. y = 0 gives d = 0.
  - `dy` is carried alongside.
- Stage 3 (S3):
  - `m = dy·d`, with WF_G+WF_D fraction bits.
  - Round half-up: add 1 << (WF_D−1), then arithmetic shift right by WF_D.
  - Saturate to the signed WI_G+WF_G range; this is a guard only, since |d| ≤ 1.
  - Register the result as `dx`.
- Each stage has a valid bit. A stage loads when it is empty or its contents move downstream in the same cycle.
  - S3 moves when `out_ready`.
  - `in_ready` = !S1.valid || S1 moves. It is combinational from `out_ready` through the stage valids.
- With `out_valid` && !`out_ready`, `dx` and all stage contents hold unchanged. When all three stages are full, `in_ready` = 0.
- `txCount` increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.

## Timing
- Latency is 3 cycles from input transfer to `out_valid`, with no stalls.
- Throughput is 1 transaction per cycle when `out_ready` is held high.
- Input accept and output drain in the same cycle with a full pipe: both occur and occupancy is unchanged.
- Reset values (asynchronous, immediate on `RST`=1):
  - all stage valids 0, so `out_valid` = 0
  - `dx` = 0
  - `txCount` = 0
  - `in_ready` = 1 once `RST` deasserts
- Reset mid-operation discards all in-flight transactions. No partial output is produced.
- The first transfer can occur on the first rising edge after `RST` falls.
- `dx` is held stable while `out_valid` && !`out_ready`. `out_valid` never drops without a transfer.

## Structure
- Shared package `psig_pkg` holds:
  - widths WI_Y/WF_Y/WI_G/WF_G/WF_D
  - fpOne constants for Q8.6 and Q1.12
  - mode encoding (logsig = 1, tanh = 0)
  - the derivative type
- One sub-module, `fxRoundSat`: parameterised round-half-up plus arithmetic shift plus signed saturation. It is used in S3 and is reusable by the PSigmoid datapath.
- Stage control is inline: three valid flops with the load-enable chain.

## Test plan
- Logsig: y=32 (0.5), dy=16384 (1.0), modeSEL=1 -> dx=4096 (0.25), `out_valid` 3 cycles after input transfer.
- Tanh: y=32, dy=16384, modeSEL=0 -> dx=12288 (0.75). Also y=64 (1.0) -> dx=0. Also y=-32 with dy=-16384 -> dx=-12288.
- ReLU: ReLU_EN=1, y=192 (3.0), dy=-5000 -> dx=-5000. Also y=0 -> dx=0. Also y=-64 -> dx=0, regardless of modeSEL.
- Clamp: logsig with y=-64 -> d=0, dx=0. Tanh with y=128 (2.0) -> d clamped to 0, dx=0. Extreme dy=0x7FFFF with logsig y=32 -> dx=0x20000 exactly, no saturation.
- Backpressure: 10 back-to-back inputs with random modes, `out_ready` toggling randomly -> outputs in order and match the reference model, `dx` stable during stalls, `in_ready`=0 only when 3 stages are full, `txCount`=10.
- Reset: assert `RST` with 2 transactions in flight -> `out_valid` and `dx` go to 0 immediately. After release, no stale output appears, `txCount`=0, and the next input completes normally.
